// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester handshake and serial-line bundle for uart_tx_arb.
// The master modport is the requester/line-watcher side. The slave modport is the scheduler.
interface uart_tx_arb_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [1:0]           i_valid;
  logic [DATA_BITS-1:0] i_data0;
  logic [DATA_BITS-1:0] i_data1;
  logic [1:0]           o_ready;
  logic                 o_tx;
  logic                 o_busy;
  logic                 o_src;
  logic                 o_done;

  modport master (
    output i_valid, i_data0, i_data1,
    input  o_ready, o_tx, o_busy, o_src, o_done
  );

  modport slave (
    input  i_valid, i_data0, i_data1,
    output o_ready, o_tx, o_busy, o_src, o_done
  );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two-requester round-robin UART transmit scheduler.
// Each frame is a start bit, then DATA_BITS data bits sent LSB first, then a stop bit.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_tx_arb #(
  parameter int unsigned CLKS_PER_BIT = 25,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  uart_tx_arb_if.slave   bus
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic                 tick, tick_nx;
  logic [BW-1:0]        bitcnt, bitcnt_nx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic                 src, src_nx;
  logic                 tx, tx_nx;
  logic                 grant;
  logic                 accept;
  logic [1:0]           ready;
`ifdef UART_TX_PARITY_EN
  logic                 par, par_nx;
`endif

  // State and datapath registers; reset drives the line idle-high immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      tick   <= 1'b0;
      bitcnt <= '0;
      shift  <= '0;
      src    <= 1'b1;
      tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      tick   <= tick_nx;
      bitcnt <= bitcnt_nx;
      shift  <= shift_nx;
      src    <= src_nx;
      tx     <= tx_nx;
`ifdef UART_TX_PARITY_EN
      par    <= par_nx;
`endif
    end
  end

  // Round-robin grant. o_src holds the last winner, so it also serves as the fairness pointer.
  always_comb begin
    grant = 1'b0;
    case (bus.i_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~src;
      default: grant = 1'b0;
    endcase
    ready = '0;
    if (state == IDLE && bus.i_valid != 2'b00) ready[grant] = 1'b1;
    accept = |(ready & bus.i_valid);
  end

  // Next-state and datapath update.
  // tick is registered one count early, so it is high on the last cycle of each bit period.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    tick_nx   = 1'b0;
    bitcnt_nx = bitcnt;
    shift_nx  = shift;
    src_nx    = src;
`ifdef UART_TX_PARITY_EN
    par_nx    = par;
`endif
    if (state == IDLE) begin
      cnt_nx    = '0;
      bitcnt_nx = '0;
      if (accept) begin
        state_nx = START;
        src_nx   = grant;
        shift_nx = grant ? bus.i_data1 : bus.i_data0;
`ifdef UART_TX_PARITY_EN
        par_nx   = ^shift_nx;
`endif
      end
    end else begin
      cnt_nx  = tick ? '0 : cnt + 1'b1;
      tick_nx = (cnt == CNT_PRE);
      if (tick) begin
        case (state)
          START: state_nx = DATA;
          DATA: begin
            shift_nx  = shift >> 1;
            bitcnt_nx = bitcnt + 1'b1;
            if (bitcnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_nx = PARITY;
`else
              state_nx = STOP;
`endif
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY:  state_nx = STOP;
`endif
          STOP:    state_nx = IDLE;
          default: state_nx = IDLE;
        endcase
      end
    end
    // The line level is computed from the next state, so the registered o_tx changes together with state.
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nx = par_nx;
`endif
      default: tx_nx = 1'b1;
    endcase
  end

  // Output decode.
  always_comb begin
    bus.o_ready = ready;
    bus.o_tx    = tx;
    bus.o_busy  = (state != IDLE);
    bus.o_src   = src;
    bus.o_done  = (state == STOP) && tick;
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: randomized self-checking bench for uart_tx_arb (CLKS_PER_BIT=4, DATA_BITS=8).
module tb_uart_tx_arb;
  localparam int unsigned CPB = 4;
  localparam int unsigned DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NB = DB + 3;
`else
  localparam int unsigned NB = DB + 2;
`endif
  localparam int unsigned NS     = NB * CPB;
  localparam int unsigned PERIOD = NS + 1;

  logic i_clk = 1'b0;
  logic i_rst_n;
  uart_tx_arb_if #(.DATA_BITS(DB)) bus ();

  uart_tx_arb #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;
  logic exp_last;  // reference model's memory of the last winner

  // Expected line level for each clock of one frame, built from the frame rules.
  function automatic logic [NS-1:0] exp_wave(input logic [DB-1:0] d);
    logic [NS-1:0] w;
    logic lvl;
    w = '0;
    for (int b = 0; b < int'(NB); b++) begin
      if (b == 0) lvl = 1'b0;
      else if (b <= int'(DB)) lvl = d[b-1];
`ifdef UART_TX_PARITY_EN
      else if (b == int'(DB) + 1) lvl = ^d;
`endif
      else lvl = 1'b1;
      for (int c = 0; c < int'(CPB); c++) w[b*CPB + c] = lvl;
    end
    return w;
  endfunction

  // Round-robin reference: a lone requester always wins, and a tie goes to the one that did not win last.
  function automatic logic model_grant(input logic [1:0] v, input logic last);
    if (v == 2'b11) return ~last;
    return v[1];
  endfunction

  // Samples one frame, starting at its first start-bit cycle. Inputs can be changed at chg_at, and valid cleared at wd_at.
  task automatic capture(input int chg_at, input logic [1:0] nv, input logic [DB-1:0] nd0,
                         input logic [DB-1:0] nd1, input int wd_at,
                         output logic [NS-1:0] smp, output int done_idx, output int done_cnt,
                         output int rdy_bad, output int busy_bad);
    smp = '0; done_idx = -1; done_cnt = 0; rdy_bad = 0; busy_bad = 0;
    for (int i = 0; i < int'(NS); i++) begin
      smp[i] = bus.o_tx;
      if (bus.o_done === 1'b1) begin done_cnt++; done_idx = i; end
      if (bus.o_ready !== 2'b00) rdy_bad++;
      if (bus.o_busy !== 1'b1) busy_bad++;
      if (i == chg_at) begin bus.i_valid = nv; bus.i_data0 = nd0; bus.i_data1 = nd1; end
      if (i == wd_at) bus.i_valid = 2'b00;
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; bus.i_valid = 2'b00; bus.i_data0 = '0; bus.i_data1 = '0;
    repeat (3) @(negedge i_clk);
    total++; if ({bus.o_tx, bus.o_busy, bus.o_src, bus.o_done} !== 4'b1010)
      $display("FAIL reset_outputs tx/busy/src/done=%b exp=1010", {bus.o_tx, bus.o_busy, bus.o_src, bus.o_done}); else passed++;
    i_rst_n = 1'b1;
    exp_last = 1'b1;
    @(negedge i_clk);
    total++; if (bus.o_ready !== 2'b00) $display("FAIL reset_ready_none got=%b exp=00", bus.o_ready); else passed++;
    bus.i_valid = 2'b11; #1;
    total++; if (bus.o_ready !== 2'b01) $display("FAIL reset_first_tie got=%b exp=01", bus.o_ready); else passed++;
    bus.i_valid = 2'b10; #1;
    total++; if (bus.o_ready !== 2'b10) $display("FAIL reset_only1 got=%b exp=10", bus.o_ready); else passed++;
    bus.i_valid = 2'b00;
    @(negedge i_clk);
  endtask

  task automatic test_single();
    logic [NS-1:0] smp; int di, dc, rb, bb;
    logic k; logic [DB-1:0] d;
    for (int n = 0; n < 5; n++) begin
      k = (n == 0) ? 1'b0 : 1'($urandom_range(1));
      d = (n == 0) ? 8'hA5 : 8'($urandom);
      bus.i_valid = k ? 2'b10 : 2'b01;
      if (k) bus.i_data1 = d; else bus.i_data0 = d;
      #1;
      total++; if (bus.o_ready !== bus.i_valid) $display("FAIL single_ready got=%b exp=%b", bus.o_ready, bus.i_valid); else passed++;
      @(negedge i_clk);
      bus.i_valid = 2'b00;
      total++; if ({bus.o_busy, bus.o_src, bus.o_tx} !== {1'b1, k, 1'b0})
        $display("FAIL single_start busy/src/tx=%b exp=%b", {bus.o_busy, bus.o_src, bus.o_tx}, {1'b1, k, 1'b0}); else passed++;
      exp_last = k;
      capture(-1, 2'b00, '0, '0, -1, smp, di, dc, rb, bb);
      total++; if (smp !== exp_wave(d)) $display("FAIL single_wave data=%h got=%h exp=%h", d, smp, exp_wave(d)); else passed++;
      total++; if (dc !== 1 || di !== int'(NS) - 1) $display("FAIL single_done idx=%0d cnt=%0d exp idx=%0d cnt=1", di, dc, NS - 1); else passed++;
      total++; if ({bus.o_busy, bus.o_tx, rb, bb} !== {1'b0, 1'b1, 32'd0, 32'd0})
        $display("FAIL single_end busy=%b tx=%b rdy_bad=%0d busy_bad=%0d exp 0 1 0 0", bus.o_busy, bus.o_tx, rb, bb); else passed++;
    end
  endtask

  task automatic test_contention();
    logic [NS-1:0] smp; int di, dc, rb, bb; int prev_start;
    logic g; logic [1:0] v, nv; logic [DB-1:0] d0, d1, nd0, nd1;
    v = 2'b11; d0 = 8'h11; d1 = 8'h22;
    bus.i_valid = v; bus.i_data0 = d0; bus.i_data1 = d1;
    prev_start = -1;
    for (int f = 0; f < 10; f++) begin
      #1;
      g = model_grant(v, exp_last);
      total++; if (bus.o_ready !== (2'b01 << g)) $display("FAIL cont_ready frame=%0d got=%b exp=%b", f, bus.o_ready, 2'b01 << g); else passed++;
      @(negedge i_clk);
      total++; if ({bus.o_src, bus.o_tx} !== {g, 1'b0}) $display("FAIL cont_src frame=%0d src/tx=%b exp=%b", f, {bus.o_src, bus.o_tx}, {g, 1'b0}); else passed++;
      if (prev_start >= 0) begin
        total++; if (cyc - prev_start !== int'(PERIOD)) $display("FAIL cont_period frame=%0d got=%0d exp=%0d", f, cyc - prev_start, PERIOD); else passed++;
      end
      prev_start = cyc;
      exp_last = g;
      if (f < 3) begin nv = v; nd0 = d0; nd1 = d1; end
      else begin nv = 2'($urandom_range(3, 1)); nd0 = 8'($urandom); nd1 = 8'($urandom); end
      capture(20, nv, nd0, nd1, -1, smp, di, dc, rb, bb);
      total++; if (smp !== exp_wave(g ? d1 : d0)) $display("FAIL cont_wave frame=%0d got=%h exp=%h", f, smp, exp_wave(g ? d1 : d0)); else passed++;
      total++; if (rb !== 0) $display("FAIL cont_ready_busy frame=%0d got=%0d exp=0", f, rb); else passed++;
      v = nv; d0 = nd0; d1 = nd1;
    end
    bus.i_valid = 2'b00;
    @(negedge i_clk);
    total++; if (bus.o_busy !== 1'b0) $display("FAIL cont_drain got=%b exp=0", bus.o_busy); else passed++;
  endtask

  task automatic test_stream();
    logic [NS-1:0] smp; int di, dc, rb, bb; int prev_start;
    bus.i_valid = 2'b10; bus.i_data1 = 8'hFF; bus.i_data0 = 8'($urandom);
    prev_start = -1;
    for (int f = 0; f < 3; f++) begin
      #1;
      total++; if (bus.o_ready !== 2'b10) $display("FAIL stream_ready frame=%0d got=%b exp=10", f, bus.o_ready); else passed++;
      @(negedge i_clk);
      if (prev_start >= 0) begin
        total++; if (cyc - prev_start !== int'(PERIOD)) $display("FAIL stream_period frame=%0d got=%0d exp=%0d", f, cyc - prev_start, PERIOD); else passed++;
      end
      prev_start = cyc;
      capture(-1, 2'b00, '0, '0, -1, smp, di, dc, rb, bb);
      total++; if ({smp, bus.o_src} !== {exp_wave(8'hFF), 1'b1}) $display("FAIL stream_wave frame=%0d got=%h src=%b exp=%h src=1", f, smp, bus.o_src, exp_wave(8'hFF)); else passed++;
      total++; if (rb !== 0) $display("FAIL stream_ready0 frame=%0d got=%0d exp=0", f, rb); else passed++;
    end
    bus.i_valid = 2'b00;
    exp_last = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_busy_change();
    logic [NS-1:0] smp; int di, dc, rb, bb;
    bus.i_valid = 2'b01; bus.i_data0 = 8'h3C;
    @(negedge i_clk);
    bus.i_valid = 2'b00;
    exp_last = 1'b0;
    capture(15, 2'b00, 8'hC3, 8'h5A, -1, smp, di, dc, rb, bb);
    total++; if (smp !== exp_wave(8'h3C)) $display("FAIL busy_change_wave got=%h exp=%h", smp, exp_wave(8'h3C)); else passed++;
  endtask

  task automatic test_withdraw();
    logic [NS-1:0] smp; int di, dc, rb, bb; int busy_seen;
    logic [DB-1:0] d;
    d = 8'($urandom);
    bus.i_valid = 2'b10; bus.i_data1 = d;
    @(negedge i_clk);
    bus.i_valid = 2'b00;
    exp_last = 1'b1;
    capture(10, 2'b01, 8'($urandom), d, 30, smp, di, dc, rb, bb);
    total++; if (smp !== exp_wave(d)) $display("FAIL withdraw_wave got=%h exp=%h", smp, exp_wave(d)); else passed++;
    total++; if (rb !== 0) $display("FAIL withdraw_ready_busy got=%0d exp=0", rb); else passed++;
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.o_busy !== 1'b0 || bus.o_tx !== 1'b1) busy_seen++;
      @(negedge i_clk);
    end
    total++; if (busy_seen !== 0) $display("FAIL withdraw_no_frame got=%0d exp=0", busy_seen); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [NS-1:0] smp; int di, dc, rb, bb;
    logic [DB-1:0] d, d0, d1;
    d = 8'($urandom) & 8'hEF;
    bus.i_valid = 2'b01; bus.i_data0 = d;
    @(negedge i_clk);
    bus.i_valid = 2'b00;
    exp_last = 1'b0;
    repeat (5 * CPB + 1) @(negedge i_clk);
    total++; if (bus.o_tx !== 1'b0) $display("FAIL rstmid_pre_tx got=%b exp=0", bus.o_tx); else passed++;
    i_rst_n = 1'b0;
    #1;
    total++; if ({bus.o_tx, bus.o_busy} !== 2'b10) $display("FAIL rstmid_async tx/busy=%b exp=10", {bus.o_tx, bus.o_busy}); else passed++;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_last = 1'b1;
    @(negedge i_clk);
    total++; if ({bus.o_busy, bus.o_tx} !== 2'b01) $display("FAIL rstmid_no_resume busy/tx=%b exp=01", {bus.o_busy, bus.o_tx}); else passed++;
    d0 = 8'($urandom); d1 = 8'($urandom);
    bus.i_valid = 2'b11; bus.i_data0 = d0; bus.i_data1 = d1;
    #1;
    total++; if (bus.o_ready !== 2'b01) $display("FAIL rstmid_grant got=%b exp=01", bus.o_ready); else passed++;
    @(negedge i_clk);
    bus.i_valid = 2'b00;
    exp_last = 1'b0;
    total++; if (bus.o_src !== 1'b0) $display("FAIL rstmid_src got=%b exp=0", bus.o_src); else passed++;
    capture(-1, 2'b00, '0, '0, -1, smp, di, dc, rb, bb);
    total++; if (smp !== exp_wave(d0)) $display("FAIL rstmid_wave got=%h exp=%h", smp, exp_wave(d0)); else passed++;
    total++; if (dc !== 1 || di !== int'(NS) - 1) $display("FAIL rstmid_done idx=%0d cnt=%0d exp idx=%0d cnt=1", di, dc, NS - 1); else passed++;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [NS-1:0] smp; int di, dc, rb, bb;
    logic [DB-1:0] d;
    for (int n = 0; n < 2; n++) begin
      d = (n == 0) ? 8'h07 : 8'h03;
      bus.i_valid = 2'b01; bus.i_data0 = d;
      @(negedge i_clk);
      bus.i_valid = 2'b00;
      exp_last = 1'b0;
      capture(-1, 2'b00, '0, '0, -1, smp, di, dc, rb, bb);
      total++; if (smp[(DB+1)*CPB] !== ^d) $display("FAIL parity_bit data=%h got=%b exp=%b", d, smp[(DB+1)*CPB], ^d); else passed++;
      total++; if (smp !== exp_wave(d)) $display("FAIL parity_wave got=%h exp=%h", smp, exp_wave(d)); else passed++;
      total++; if (di !== int'(NS) - 1) $display("FAIL parity_len done_idx=%0d exp=%0d", di, NS - 1); else passed++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stream();
    test_busy_change();
    test_withdraw();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
